mult8_error_sweeper: RTL and testbench
======================================

Name: mult8_error_sweeper

Overview:
- Sequential evaluation stage wrapped around one candidate approximate 8x8 multiplier from the GA population (e.g. multiplier8bit_NN).
- Sweeps every operand pair exhaustively and drives it into the candidate.
- Captures the candidate's combinational product and computes the exact product internally.
- Accumulates error metrics (sum of error distance, max error, error count) that the GA fitness step reads after `done`.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- ACC_W, 40, width of the sum-of-error-distance accumulator; the minimum legal value is 2*WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- abort  in  1  synchronous stop; returns the block to IDLE.
- op_a  out  WIDTH  registered operand A to the candidate multiplier.
- op_b  out  WIDTH  registered operand B to the candidate multiplier.
- approx_p  in  2*WIDTH  candidate product; combinational function of op_a/op_b.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the results become final.
- sum_ed  out  ACC_W  sum over pairs of |exact - approx|.
- max_ed  out  2*WIDTH  largest single error distance.
- err_count  out  2*WIDTH+1  number of pairs with approx_p != exact.
- sample_count  out  2*WIDTH+1  number of pairs accumulated.
- sat  out  1  sticky flag; set when sum_ed saturates.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; op_a=op_b=0.
  - All pipeline valids=0.
  - busy=done=sat=0; sum_ed=max_ed=err_count=sample_count=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start -> RUN. Clear all accumulators and sat; op_a=op_b=0; issue counter=0.
  - RUN: each cycle issue pair {op_a,op_b}, with op_b inner and op_a outer (a 2*WIDTH-bit counter). After the pair {all-ones, all-ones} is issued -> DRAIN. No wrap-around is issued.
  - DRAIN: stay until all pipeline valids are 0, which takes exactly 3 cycles. Then -> DONE and assert done for 1 cycle.
  - DONE: results are held stable until the next start.
- Pipeline, for the pair issued in cycle k:
  - S1 captures op_a, op_b, approx_p at the end of cycle k.
  - S2 registers exact = op_a*op_b (full 2*WIDTH) and ed = |exact - approx_p|, using unsigned magnitude, with no truncation.
  - S3 updates the accumulators at the end of cycle k+2.
- Accumulator rules on each valid S3 update:
  - sample_count += 1.
  - err_count += (ed != 0).
  - max_ed = max(max_ed, ed).
  - sum_ed += ed, saturating at 2^ACC_W-1. On saturation sat=1 (sticky) and sum_ed holds all-ones.
- Run length: a full sweep takes 2^(2*WIDTH) RUN cycles + 3 DRAIN cycles; start to done = 65539 cycles at default.
- start while busy: ignored; it has no effect on counters or results.
- abort:
  - Any state -> IDLE next cycle; pipeline valids cleared; op_a/op_b return to 0.
  - Accumulators hold their partial values.
  - done is not pulsed; busy falls the next cycle.
  - abort has priority over a same-cycle start.
- Reset mid-sweep: immediate return to reset values; no done.
- op_a/op_b must not change within a cycle; approx_p is sampled only on clk edges.

Decomposition:
- Shared package (mult_eval_pkg):
  - FSM state enum.
  - Default WIDTH/ACC_W constants.
  - Function abs_diff(exact, approx).
- One sub-module, mult_err_accum: S2+S3 datapath (ed computation, saturating sum, max, counts) with a valid/clear interface.
- The candidate multiplier is instantiated outside this block by the GA harness.

Test Plan:
- approx_p tied to exact op_a*op_b, full sweep -> sum_ed=0, max_ed=0, err_count=0, sample_count=65536, sat=0, done exactly 65539 cycles after start.
- approx_p tied to 0 -> sum_ed=1065369600 (32640^2), max_ed=65025, err_count=65025, sample_count=65536.
- approx_p = exact XOR 1 -> sum_ed=65536, max_ed=1, err_count=65536.
- ACC_W=16, approx_p=0 -> sat=1, sum_ed=65535, max_ed=65025, sample_count=65536.
- start pulsed again at cycle 100 of a sweep, then abort at cycle 1000 -> second start ignored; IDLE next cycle; busy=0; no done pulse.
- rst_n low mid-sweep, then a new start -> all outputs zero during reset; next sweep gives the same results as an undisturbed sweep.

Source files
------------

// File: rtl/mult_eval_pkg.sv
// Shared types, defaults and helpers for the approximate-multiplier error sweeper.
package mult_eval_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned ACC_W_DEF = 40;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // Unsigned error distance; callers size-cast the result to their product width.
  function automatic logic [63:0] abs_diff(input logic [63:0] exact,
                                           input logic [63:0] approx);
    return (exact >= approx) ? (exact - approx) : (approx - exact);
  endfunction

endpackage

// File: rtl/mult8_error_sweeper_if.sv
// Operand/product bus between the sweeper and the candidate multiplier under test.
interface mult8_error_sweeper_if
  import mult_eval_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] approx_p;

  modport master (output op_a, output op_b, input approx_p);
  modport slave  (input op_a, input op_b, output approx_p);

endinterface

// File: rtl/mult_err_accum.sv
// S2/S3 datapath: error distance against the exact product, then saturating
// sum, running maximum and pair counters.
module mult_err_accum
  import mult_eval_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] p_i,
  output logic               valid_o,
  output logic [ACC_W-1:0]   sum_ed_o,
  output logic [2*WIDTH-1:0] max_ed_o,
  output logic [2*WIDTH:0]   err_count_o,
  output logic [2*WIDTH:0]   sample_count_o,
  output logic               sat_o
);

  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned AW1 = ACC_W + 1;

  logic [PW-1:0]    exact_w;
  logic [PW-1:0]    ed_w;
  logic             v2_q;
  logic [PW-1:0]    ed_q;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [PW-1:0]    max_q, max_d;
  logic [PW:0]      err_q, err_d;
  logic [PW:0]      smp_q, smp_d;
  logic             sat_q, sat_d;
  logic [ACC_W:0]   sum_ext;

  assign exact_w = PW'(a_i) * PW'(b_i);
  assign ed_w    = PW'(abs_diff(64'(exact_w), 64'(p_i)));

  // S2: only the distance is kept; the exact product is consumed here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
      ed_q <= '0;
    end else begin
      v2_q <= valid_i && !flush_i;
      if (valid_i) ed_q <= ed_w;
    end
  end

  // S3 next-state: clear on sweep start, otherwise fold in one valid sample.
  always_comb begin
    sum_d   = sum_q;
    max_d   = max_q;
    err_d   = err_q;
    smp_d   = smp_q;
    sat_d   = sat_q;
    sum_ext = {1'b0, sum_q} + AW1'(ed_q);
    if (clear_i) begin
      sum_d = '0;
      max_d = '0;
      err_d = '0;
      smp_d = '0;
      sat_d = 1'b0;
    end else if (v2_q && !flush_i) begin
      smp_d = smp_q + 1'b1;
      if (ed_q != '0) err_d = err_q + 1'b1;
      if (ed_q > max_q) max_d = ed_q;
      if (sum_ext[ACC_W]) begin
        sum_d = '1;
        sat_d = 1'b1;
      end else begin
        sum_d = sum_ext[ACC_W-1:0];
      end
    end
  end

  // S3 accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      max_q <= '0;
      err_q <= '0;
      smp_q <= '0;
      sat_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      max_q <= max_d;
      err_q <= err_d;
      smp_q <= smp_d;
      sat_q <= sat_d;
    end
  end

  assign valid_o        = v2_q;
  assign sum_ed_o       = sum_q;
  assign max_ed_o       = max_q;
  assign err_count_o    = err_q;
  assign sample_count_o = smp_q;
  assign sat_o          = sat_q;

endmodule

// File: rtl/mult8_error_sweeper.sv
// Exhaustive operand sweep of one candidate multiplier with error-metric
// accumulation; results are final when done pulses.
module mult8_error_sweeper
  import mult_eval_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         abort_i,
  mult8_error_sweeper_if.master        cand,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [ACC_W-1:0]             sum_ed_o,
  output logic [2*WIDTH-1:0]           max_ed_o,
  output logic [2*WIDTH:0]             err_count_o,
  output logic [2*WIDTH:0]             sample_count_o,
  output logic                         sat_o
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, b1_q;
  logic [PW-1:0]    p1_q;
  logic             v2;
  logic             clear;
  logic             drained;

  assign drained = !v1_q && !v2;

  // Next state, issue counter and S1 valid; abort overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    v1_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RUN;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        v1_d = 1'b1;
        if (cnt_q == '1) state_d = S_DRAIN;
        else             cnt_d   = cnt_q + 1'b1;
      end
      S_DRAIN: begin
        if (drained) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      clear   = 1'b0;
      v1_d    = 1'b0;
    end
  end

  // State and issue-counter registers; the counter is the operand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // S1 capture of the issued pair and the candidate's product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      p1_q <= '0;
    end else begin
      v1_q <= v1_d;
      if (v1_d) begin
        a1_q <= cand.op_a;
        b1_q <= cand.op_b;
        p1_q <= cand.approx_p;
      end
    end
  end

  assign cand.op_a = cnt_q[PW-1:WIDTH];
  assign cand.op_b = cnt_q[WIDTH-1:0];

  mult_err_accum #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_accum (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (clear),
    .flush_i        (abort_i),
    .valid_i        (v1_q),
    .a_i            (a1_q),
    .b_i            (b1_q),
    .p_i            (p1_q),
    .valid_o        (v2),
    .sum_ed_o       (sum_ed_o),
    .max_ed_o       (max_ed_o),
    .err_count_o    (err_count_o),
    .sample_count_o (sample_count_o),
    .sat_o          (sat_o)
  );

  assign busy_o = (state_q == S_RUN) || (state_q == S_DRAIN);
  // Pulses in the last DRAIN cycle, once the final update has landed.
  assign done_o = (state_q == S_DRAIN) && drained && !abort_i;

endmodule

// File: tb/tb_mult8_error_sweeper.sv
// Bench: small WIDTH=4 instance for randomized sweeps against a table model,
// plus two WIDTH=8 instances (wide and 16-bit accumulator) for the full sweep.
module tb_mult8_error_sweeper;

  logic clk;
  logic rst_n, rst4_n;
  logic start8, abort8, start4, abort4;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] tbl [256];

  mult8_error_sweeper_if #(.WIDTH(8)) if8a ();
  mult8_error_sweeper_if #(.WIDTH(8)) if8b ();
  mult8_error_sweeper_if #(.WIDTH(4)) if4 ();

  assign if8a.approx_p = '0;
  assign if8b.approx_p = '0;
  assign if4.approx_p  = tbl[{if4.op_a, if4.op_b}];

  logic        busy8a, done8a, sat8a;
  logic [39:0] sum8a;
  logic [15:0] max8a;
  logic [16:0] err8a, smp8a;

  logic        busy8b, done8b, sat8b;
  logic [15:0] sum8b;
  logic [15:0] max8b;
  logic [16:0] err8b, smp8b;

  logic        busy4, done4, sat4;
  logic [39:0] sum4;
  logic [7:0]  max4;
  logic [8:0]  err4, smp4;

  mult8_error_sweeper #(.WIDTH(8), .ACC_W(40)) dut8a (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .abort_i(abort8), .cand(if8a),
    .busy_o(busy8a), .done_o(done8a), .sum_ed_o(sum8a), .max_ed_o(max8a),
    .err_count_o(err8a), .sample_count_o(smp8a), .sat_o(sat8a));

  mult8_error_sweeper #(.WIDTH(8), .ACC_W(16)) dut8b (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .abort_i(abort8), .cand(if8b),
    .busy_o(busy8b), .done_o(done8b), .sum_ed_o(sum8b), .max_ed_o(max8b),
    .err_count_o(err8b), .sample_count_o(smp8b), .sat_o(sat8b));

  mult8_error_sweeper #(.WIDTH(4), .ACC_W(40)) dut4 (
    .clk(clk), .rst_n(rst4_n), .start_i(start4), .abort_i(abort4), .cand(if4),
    .busy_o(busy4), .done_o(done4), .sum_ed_o(sum4), .max_ed_o(max4),
    .err_count_o(err4), .sample_count_o(smp4), .sat_o(sat4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Candidate behaviour for the WIDTH=4 instance, as a lookup table.
  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) begin
      int unsigned x;
      x = (i / 16) * (i % 16);
      case (mode)
        0:       tbl[i] = 8'(x);
        1:       tbl[i] = 8'(x ^ 1);
        2:       tbl[i] = 8'(0);
        default: tbl[i] = ($urandom_range(0, 1) == 1) ? 8'(x) : 8'($urandom);
      endcase
    end
  endtask

  // Expected metrics over all 256 pairs directly from the table.
  task automatic model4(output longint s, output longint m, output longint e, output longint n);
    s = 0; m = 0; e = 0; n = 0;
    for (int i = 0; i < 256; i++) begin
      longint x, y, d;
      x = (i / 16) * (i % 16);
      y = tbl[i];
      d = (x > y) ? x - y : y - x;
      s += d;
      if (d > m) m = d;
      if (d != 0) e++;
      n++;
    end
  endtask

  task automatic sweep4(input string tag, input bit restart_mid);
    longint es, em, ee, en;
    int n;
    model4(es, em, ee, en);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 400) begin
      if (n <= 256) chk({tag, "_op"}, 64'({if4.op_a, if4.op_b}), 64'(n - 1));
      start4 = (restart_mid && n == 50);
      @(negedge clk);
      n++;
    end
    start4 = 1'b0;
    chk({tag, "_done_cycle"}, 64'(n), 64'd259);
    chk({tag, "_busy_at_done"}, 64'(busy4), 64'd1);
    chk({tag, "_sum"}, 64'(sum4), es);
    chk({tag, "_max"}, 64'(max4), em);
    chk({tag, "_err"}, 64'(err4), ee);
    chk({tag, "_samples"}, 64'(smp4), en);
    chk({tag, "_sat"}, 64'(sat4), 64'd0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(done4), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy4), 64'd0);
    chk({tag, "_sum_held"}, 64'(sum4), es);
  endtask

  initial begin
    longint es, em, ee, en;
    int n;
    bit saw_done;

    rst_n = 1'b0; rst4_n = 1'b0;
    start8 = 1'b0; abort8 = 1'b0; start4 = 1'b0; abort4 = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst_busy8", 64'(busy8a), 64'd0);
    chk("rst_done8", 64'(done8a), 64'd0);
    chk("rst_sum8", 64'(sum8a), 64'd0);
    chk("rst_smp8", 64'(smp8a), 64'd0);
    chk("rst_ops8", 64'({if8a.op_a, if8a.op_b}), 64'd0);
    chk("rst_sat8b", 64'(sat8b), 64'd0);
    chk("rst_busy4", 64'(busy4), 64'd0);
    rst_n = 1'b1; rst4_n = 1'b1;
    @(negedge clk);

    // WIDTH=4 sweeps: exact, xor-1 (with ignored start mid-run), zero, random.
    fill(0); sweep4("exact4", 1'b0);
    fill(1); sweep4("xor4", 1'b1);
    fill(2); sweep4("zero4", 1'b0);
    fill(3); sweep4("rand4", 1'b0);

    // Abort beats start in DONE; accumulators stay at the last results.
    model4(es, em, ee, en);
    start4 = 1'b1; abort4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; abort4 = 1'b0;
    chk("prio_busy", 64'(busy4), 64'd0);
    chk("prio_smp_held", 64'(smp4), en);
    chk("prio_sum_held", 64'(sum4), es);
    @(negedge clk);
    chk("prio_busy2", 64'(busy4), 64'd0);

    // Reset mid-sweep, then an undisturbed sweep on a fresh random table.
    fill(3);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (100) @(negedge clk);
    rst4_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy4), 64'd0);
    chk("mrst_done", 64'(done4), 64'd0);
    chk("mrst_sum", 64'(sum4), 64'd0);
    chk("mrst_max", 64'(max4), 64'd0);
    chk("mrst_err", 64'(err4), 64'd0);
    chk("mrst_smp", 64'(smp4), 64'd0);
    chk("mrst_ops", 64'({if4.op_a, if4.op_b}), 64'd0);
    repeat (2) @(negedge clk);
    rst4_n = 1'b1;
    @(negedge clk);
    fill(3);
    sweep4("after_rst4", 1'b0);

    // WIDTH=8: second start at cycle 100 ignored, abort at cycle 1000.
    saw_done = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (n < 1000) begin
      if (done8a || done8b) saw_done = 1'b1;
      if (n == 999) chk("abort8_op_progress", 64'({if8a.op_a, if8a.op_b}), 64'd998);
      start8 = (n == 100);
      @(negedge clk);
      n++;
    end
    start8 = 1'b0;
    abort8 = 1'b1;
    if (done8a) saw_done = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    chk("abort8_busy", 64'(busy8a), 64'd0);
    chk("abort8_busy_b", 64'(busy8b), 64'd0);
    chk("abort8_ops", 64'({if8a.op_a, if8a.op_b}), 64'd0);
    repeat (3) begin
      if (done8a || done8b) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("abort8_no_done", 64'(saw_done), 64'd0);

    // WIDTH=8 full sweep with approx_p tied to zero.
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (!done8a && n < 70000) begin
      @(negedge clk);
      n++;
    end
    chk("full8_done_cycle", 64'(n), 64'd65539);
    chk("full8_done_b", 64'(done8b), 64'd1);
    chk("full8_sum", 64'(sum8a), 64'd1065369600);
    chk("full8_max", 64'(max8a), 64'd65025);
    chk("full8_err", 64'(err8a), 64'd65025);
    chk("full8_smp", 64'(smp8a), 64'd65536);
    chk("full8_sat", 64'(sat8a), 64'd0);
    chk("acc16_sat", 64'(sat8b), 64'd1);
    chk("acc16_sum", 64'(sum8b), 64'd65535);
    chk("acc16_max", 64'(max8b), 64'd65025);
    chk("acc16_smp", 64'(smp8b), 64'd65536);
    chk("acc16_err", 64'(err8b), 64'd65025);
    @(negedge clk);
    chk("full8_done_1cyc", 64'(done8a), 64'd0);
    chk("full8_sum_held", 64'(sum8a), 64'd1065369600);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
